pc_unit: RTL and testbench
==========================

# pc_unit

Sequential program-counter stage of the single-cycle RISC-V core. It sits directly downstream of the branch-decision gate: it consumes `pc_src` (branch & zero) together with the immediate branch offset, and computes and registers the next PC. It also detects misaligned branch targets, redirecting the PC to a trap vector, and maintains cycle and retired-instruction counters for the CSR path.

## Interface
Parameters:
- `XLEN`, 32 — datapath width.
- `RESET_VECTOR`, 32'h0000_0000 — PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0100 — PC loaded on a misaligned-target trap.

Ports:
- `clk`  in  1  — the single clock; all state updates on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `pc_src`  in  1  — take-branch select from the branch-decision gate.
- `imm`  in  XLEN  — sign-extended branch offset, in bytes.
- `stall`  in  1  — hold the PC this cycle.
- `trap_clear`  in  1  — trap acknowledge from the control unit.
- `pc`  out  XLEN  — current PC, registered.
- `pc_plus4`  out  XLEN  — `pc + 4`, combinational.
- `branch_target`  out  XLEN  — `pc + imm`, combinational.
- `misalign_trap`  out  1  — high while in TRAP state, registered.
- `trap_pc`  out  XLEN  — faulting target address, registered.
- `cycle_cnt`  out  64  — free-running cycle counter.
- `instret_cnt`  out  64  — retired-instruction counter.

## Operation
- FSM has two states: RUN and TRAP.
- Arithmetic:
  - `pc_plus4` and `branch_target` wrap modulo 2^XLEN; no overflow flag.
  - A target is misaligned when `branch_target[1:0] != 2'b00`. There is no C extension.
- RUN, in priority order:
  - `stall`=1: `pc` holds, `instret_cnt` holds, and `pc_src` is ignored.
  - `pc_src`=1 with a misaligned target: `pc` <= TRAP_VECTOR, `trap_pc` <= `branch_target`, state -> TRAP. `instret_cnt` does not increment.
  - `pc_src`=1 with an aligned target: `pc` <= `branch_target`, `instret_cnt`++.
  - Otherwise: `pc` <= `pc_plus4`, `instret_cnt`++.
- TRAP:
  - `pc` holds TRAP_VECTOR. `stall` and `pc_src` are ignored.
  - `misalign_trap`=1 for every cycle spent in TRAP.
  - `trap_clear`=1: state -> RUN on the next edge, `misalign_trap` -> 0, `pc` stays at TRAP_VECTOR (the handler starts there). `trap_pc` retains its value until the next trap.
  - `trap_clear` in RUN has no effect.
- `cycle_cnt` increments on every edge out of reset, regardless of state or stall.
- Both counters wrap at 2^64 - 1 -> 0.
- Reset (any time, including mid-trap or mid-stall):
  - `pc`=RESET_VECTOR, state=RUN.
  - `misalign_trap`=0, `trap_pc`=0.
  - `cycle_cnt`=0, `instret_cnt`=0.

## Timing
- Latency:
  - `pc` updates one edge after the inputs are sampled.
  - `pc_plus4` and `branch_target` follow `pc` combinationally in the same cycle.
- `misalign_trap` rises on the same edge that loads TRAP_VECTOR. It falls on the edge that samples `trap_clear`=1.
- Minimum TRAP residency is 1 cycle: a trap edge followed by `trap_clear` in the next cycle returns to RUN at the following edge.
- Reset assertion takes effect immediately and asynchronously. Release synchronisation is provided externally. The first edge after release performs a normal RUN update from RESET_VECTOR.
- The counters are registered, so their values lag the event they count by one edge.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`
  - state typedef `pc_state_t` {PC_RUN, PC_TRAP}
  - `INSTR_BYTES`=4
  - `ALIGN_MASK`=2'b11
- Sub-module `perf_counter`:
  - 64-bit enable-gated counter with async active-low reset.
  - Instantiated twice: `cycle_cnt` (enable=1) and `instret_cnt` (enable=retire).

## Test plan
- Reset release, `pc_src`=0, `stall`=0 for 3 cycles -> `pc` = 0x0, 0x4, 0x8, 0xC; `instret_cnt`=3, `cycle_cnt`=3.
- At `pc`=0x10, `pc_src`=1, `imm`=0xFFFF_FFF8 -> next `pc`=0x08. Wrap case: `pc`=0xFFFF_FFFC with `pc_src`=0 -> next `pc`=0x0.
- `stall`=1 for 2 cycles with `pc_src`=1 at `pc`=0x20 -> `pc` stays 0x20, `instret_cnt` unchanged, `cycle_cnt` +2.
- At `pc`=0x40, `pc_src`=1, `imm`=0x6 -> `pc`=0x100, `misalign_trap`=1, `trap_pc`=0x46, `instret_cnt` unchanged.
- Hold TRAP 4 cycles, then pulse `trap_clear` -> `misalign_trap` falls next edge and `pc` advances 0x100 -> 0x104 one edge later.
- Assert `rst_n`=0 mid-trap, asynchronously -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core datapath.
//   XLEN        : architectural register / PC width
//   pc_state_t  : program-counter sequencer states
//   INSTR_BYTES : size of one (uncompressed) instruction in bytes
//   ALIGN_MASK  : low PC bits that must be zero for a legal target
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_TRAP = 1'b1
  } pc_state_t;

endpackage

// File: rtl/perf_counter.sv
// 64-bit enable-gated performance counter.
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count enable for this cycle
//   count : current count, wraps from 2^64-1 to 0
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle core. Selects and registers the
// next PC from pc+4 or the branch target, traps on misaligned branch targets
// and keeps the cycle / retired-instruction counters for the CSR path.
//   clk           : clock
//   rst_n         : asynchronous active-low reset
//   pc_src        : take-branch select from the branch-decision gate
//   imm           : sign-extended branch offset in bytes
//   stall         : hold the PC this cycle
//   trap_clear    : trap acknowledge from the control unit
//   pc            : current PC (registered)
//   pc_plus4      : pc + 4 (combinational)
//   branch_target : pc + imm (combinational)
//   misalign_trap : high while in the trap state (registered)
//   trap_pc       : faulting branch target of the last trap (registered)
//   cycle_cnt     : free-running cycle counter
//   instret_cnt   : retired-instruction counter
module pc_unit
  import riscv_pkg::*;
#(
  parameter int                XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic            stall,
  input  logic            trap_clear,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  pc_state_t state;
  logic      misaligned;
  logic      retire;

  // Both adds wrap modulo 2^XLEN; a negative imm works via two's complement.
  assign pc_plus4      = pc + XLEN'(INSTR_BYTES);
  assign branch_target = pc + imm;
  assign misaligned    = |(branch_target[1:0] & ALIGN_MASK);

  // An instruction retires on every unstalled RUN cycle except the one that
  // takes a misaligned branch (that instruction faults instead).
  assign retire = (state == PC_RUN) && !stall && !(pc_src && misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PC_RUN;
      pc            <= RESET_VECTOR;
      misalign_trap <= 1'b0;
      trap_pc       <= '0;
    end else begin
      case (state)
        PC_RUN: begin
          if (!stall) begin
            if (pc_src && misaligned) begin
              state         <= PC_TRAP;
              pc            <= TRAP_VECTOR;
              trap_pc       <= branch_target;
              misalign_trap <= 1'b1;
            end else if (pc_src) begin
              pc <= branch_target;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        PC_TRAP: begin
          // PC parks on the vector; the handler starts there once cleared.
          if (trap_clear) begin
            state         <= PC_RUN;
            misalign_trap <= 1'b0;
          end
        end
        default: begin
          state         <= PC_RUN;
          misalign_trap <= 1'b0;
        end
      endcase
    end
  end

  perf_counter u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  perf_counter u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (instret_cnt)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] imm;
  logic        stall;
  logic        trap_clear;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        misalign_trap;
  logic [31:0] trap_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  int tests = 0;
  int fails = 0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_src        (pc_src),
    .imm           (imm),
    .stall         (stall),
    .trap_clear    (trap_clear),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .misalign_trap (misalign_trap),
    .trap_pc       (trap_pc),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic e_trap,
                             input logic [31:0] e_tpc, input logic [63:0] e_cyc,
                             input logic [63:0] e_ret);
    check({tag, ".pc"}, 64'(pc), 64'(e_pc));
    check({tag, ".trap"}, 64'(misalign_trap), 64'(e_trap));
    check({tag, ".trap_pc"}, 64'(trap_pc), 64'(e_tpc));
    check({tag, ".cycle"}, cycle_cnt, e_cyc);
    check({tag, ".instret"}, instret_cnt, e_ret);
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 1'b0; imm = 32'h0; stall = 1'b0; trap_clear = 1'b0;
    #22;
    check_state("reset", 32'h0, 1'b0, 32'h0, 64'd0, 64'd0);
    check("reset.pc_plus4", 64'(pc_plus4), 64'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from the reset vector
    step(); check("seq1.pc", 64'(pc), 64'h4);
    step(); check("seq2.pc", 64'(pc), 64'h8);
    step(); check_state("seq3", 32'hC, 1'b0, 32'h0, 64'd3, 64'd3);
    step(); check("seq4.pc", 64'(pc), 64'h10);

    // Backward branch 0x10 - 8
    pc_src = 1'b1; imm = 32'hFFFF_FFF8;
    #1 check("back.target", 64'(branch_target), 64'h8);
    step(); check_state("back", 32'h8, 1'b0, 32'h0, 64'd5, 64'd5);

    // Branch to the top of the address space, then wrap via pc+4
    imm = 32'hFFFF_FFF4;
    step(); check("top.pc", 64'(pc), 64'hFFFF_FFFC);
    pc_src = 1'b0;
    #1 check("wrap.pc_plus4", 64'(pc_plus4), 64'h0);
    step(); check_state("wrap", 32'h0, 1'b0, 32'h0, 64'd7, 64'd7);

    // Go to 0x20, then stall 2 cycles with a (misaligned) branch request
    pc_src = 1'b1; imm = 32'h20;
    step(); check("to20.pc", 64'(pc), 64'h20);
    stall = 1'b1; imm = 32'h6;
    step(); step();
    check_state("stall", 32'h20, 1'b0, 32'h0, 64'd10, 64'd8);
    stall = 1'b0;

    // Go to 0x40, then branch by +6 -> misaligned trap
    imm = 32'h20;
    step(); check("to40.pc", 64'(pc), 64'h40);
    imm = 32'h6;
    #1 check("mis.target", 64'(branch_target), 64'h46);
    step(); check_state("trap", 32'h100, 1'b1, 32'h46, 64'd12, 64'd9);

    // Hold in TRAP 4 cycles; pc_src/stall must be ignored
    stall = 1'b0; step();
    stall = 1'b1; step();
    stall = 1'b0; step();
    step();
    check_state("hold", 32'h100, 1'b1, 32'h46, 64'd16, 64'd9);

    // Acknowledge: flag drops, pc stays on the vector, then advances
    pc_src = 1'b0; trap_clear = 1'b1;
    step(); check_state("clear", 32'h100, 1'b0, 32'h46, 64'd17, 64'd9);
    trap_clear = 1'b0;
    step(); check_state("resume", 32'h104, 1'b0, 32'h46, 64'd18, 64'd10);

    // trap_clear while running is a no-op
    trap_clear = 1'b1;
    step(); check_state("clr_run", 32'h108, 1'b0, 32'h46, 64'd19, 64'd11);
    trap_clear = 1'b0;

    // Minimum residency: trap edge, clear next cycle
    pc_src = 1'b1; imm = 32'h1;
    step(); check_state("trap2", 32'h100, 1'b1, 32'h109, 64'd20, 64'd11);
    pc_src = 1'b0; trap_clear = 1'b1;
    step(); check_state("clear2", 32'h100, 1'b0, 32'h109, 64'd21, 64'd11);
    trap_clear = 1'b0;

    // Re-enter TRAP, then reset asynchronously between edges
    pc_src = 1'b1; imm = 32'h2;
    step(); check_state("trap3", 32'h100, 1'b1, 32'h102, 64'd22, 64'd11);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_state("async_rst", 32'h0, 1'b0, 32'h0, 64'd0, 64'd0);
    pc_src = 1'b0; stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(); check_state("post_rst", 32'h4, 1'b0, 32'h0, 64'd1, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
